// File: rtl/maze_pkg.sv
// Shared maze board definitions: cell encodings, coordinate/address widths
// and the memory arbiter's state and owner encodings.
package maze_pkg;

  localparam int COORD_W           = 5;
  localparam int ADDR_W            = 10;
  localparam int CELL_W            = 3;
  localparam int DEFAULT_BOARD_DIM = 24;

  typedef enum logic [CELL_W-1:0] {
    OCCUPIED      = 3'd0,
    AVAILABLE     = 3'd1,
    START         = 3'd2,
    END           = 3'd3,
    YOUR_POSITION = 3'd4
  } cell_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_WR   = 2'd0,
    OWN_CHK  = 2'd1,
    OWN_DRAW = 2'd2
  } owner_e;

  // Board RAM is row-major: row y selects a 32-cell stripe.
  function automatic logic [ADDR_W-1:0] pack_addr(input logic [COORD_W-1:0] y,
                                                  input logic [COORD_W-1:0] x);
    return {y, x};
  endfunction

endpackage

// File: rtl/maze_mem_arbiter_if.sv
// Requester and RAM signals of the maze board arbiter; the arbiter takes the
// slave view, requesters plus the RAM take the master view.
interface maze_mem_arbiter_if;

  logic                          chk_req;
  logic [maze_pkg::COORD_W-1:0]  chk_x;
  logic [maze_pkg::COORD_W-1:0]  chk_y;
  logic                          chk_gnt;
  logic                          chk_valid;
  logic [maze_pkg::CELL_W-1:0]   chk_data;

  logic                          draw_req;
  logic [maze_pkg::COORD_W-1:0]  draw_x;
  logic [maze_pkg::COORD_W-1:0]  draw_y;
  logic                          draw_gnt;
  logic                          draw_valid;
  logic [maze_pkg::CELL_W-1:0]   draw_data;

  logic                          wr_req;
  logic [maze_pkg::COORD_W-1:0]  wr_x;
  logic [maze_pkg::COORD_W-1:0]  wr_y;
  logic [maze_pkg::CELL_W-1:0]   wr_data;
  logic                          wr_gnt;

  logic [maze_pkg::ADDR_W-1:0]   mem_addr;
  logic                          mem_wren;
  logic [maze_pkg::CELL_W-1:0]   mem_wdata;
  logic [maze_pkg::CELL_W-1:0]   mem_rdata;

  modport slave (
    input  chk_req, chk_x, chk_y, draw_req, draw_x, draw_y,
           wr_req, wr_x, wr_y, wr_data, mem_rdata,
    output chk_gnt, chk_valid, chk_data, draw_gnt, draw_valid, draw_data,
           wr_gnt, mem_addr, mem_wren, mem_wdata
  );

  modport master (
    output chk_req, chk_x, chk_y, draw_req, draw_x, draw_y,
           wr_req, wr_x, wr_y, wr_data, mem_rdata,
    input  chk_gnt, chk_valid, chk_data, draw_gnt, draw_valid, draw_data,
           wr_gnt, mem_addr, mem_wren, mem_wdata
  );

endinterface

// File: rtl/maze_arb_select.sv
// Priority pick among the three requesters, with a starvation counter that
// hands the display port top priority after repeated losses.
module maze_arb_select #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       arb_en,
  input  logic       wr_req,
  input  logic       chk_req,
  input  logic       draw_req,
  output logic [2:0] grant
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  logic [2:0] starve_cnt;
  logic       starved;

  assign starved = (starve_cnt == LIMIT);

  // grant is one-hot {draw, chk, wr}
  always_comb begin
    grant = 3'b000;
    if (starved) begin
      if (draw_req)     grant = 3'b100;
      else if (chk_req) grant = 3'b010;
      else if (wr_req)  grant = 3'b001;
    end else begin
      if (wr_req)        grant = 3'b001;
      else if (chk_req)  grant = 3'b010;
      else if (draw_req) grant = 3'b100;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= 3'd0;
    end else if (arb_en) begin
      if (grant[2])                 starve_cnt <= 3'd0;
      else if (draw_req && !starved) starve_cnt <= starve_cnt + 3'd1;
    end
  end

endmodule

// File: rtl/maze_mem_arbiter.sv
// Single-port board RAM arbiter for the legality checker, display and marker
// writer; one transaction in flight, reads return data two cycles after grant.
//
//   state    | meaning
//   ST_IDLE  | no transaction; arbitrate on any request
//   ST_ISSUE | grant owner, present address (and write strobe)
//   ST_WAIT  | RAM read latency; data captured on exit
module maze_mem_arbiter
  import maze_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int BOARD_DIM    = DEFAULT_BOARD_DIM
) (
  input  logic              clock,
  input  logic              resetn,
  maze_mem_arbiter_if.slave bus
);

  localparam logic [COORD_W:0] DIM = (COORD_W+1)'(BOARD_DIM);

  arb_state_e          state, state_nxt;
  owner_e              owner, sel_owner;
  logic [2:0]          grant;
  logic                arb_en, op_legal, sel_legal;
  logic [COORD_W-1:0]  sel_x, sel_y;
  logic [ADDR_W-1:0]   addr_q;
  logic [CELL_W-1:0]   wdata_q, rd_cell, chk_data_q, draw_data_q;
  logic                chk_valid_q, draw_valid_q;

  assign arb_en = (state == ST_IDLE) && (bus.wr_req || bus.chk_req || bus.draw_req);

  maze_arb_select #(.STARVE_LIMIT(STARVE_LIMIT)) u_select (
    .clock    (clock),
    .resetn   (resetn),
    .arb_en   (arb_en),
    .wr_req   (bus.wr_req),
    .chk_req  (bus.chk_req),
    .draw_req (bus.draw_req),
    .grant    (grant)
  );

  always_comb begin
    sel_owner = OWN_DRAW;
    sel_x     = bus.draw_x;
    sel_y     = bus.draw_y;
    if (grant[0]) begin
      sel_owner = OWN_WR;
      sel_x     = bus.wr_x;
      sel_y     = bus.wr_y;
    end else if (grant[1]) begin
      sel_owner = OWN_CHK;
      sel_x     = bus.chk_x;
      sel_y     = bus.chk_y;
    end
    sel_legal = ({1'b0, sel_x} < DIM) && ({1'b0, sel_y} < DIM);
  end

  always_comb begin
    state_nxt    = state;
    bus.wr_gnt   = 1'b0;
    bus.chk_gnt  = 1'b0;
    bus.draw_gnt = 1'b0;
    bus.mem_wren = 1'b0;
    case (state)
      ST_IDLE: if (arb_en) state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        bus.wr_gnt   = (owner == OWN_WR);
        bus.chk_gnt  = (owner == OWN_CHK);
        bus.draw_gnt = (owner == OWN_DRAW);
        bus.mem_wren = (owner == OWN_WR) && op_legal;
        state_nxt    = (owner == OWN_WR) ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Off-board reads still take the RAM slot but report the cell as blocked.
  assign rd_cell = op_legal ? bus.mem_rdata : OCCUPIED;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      owner        <= OWN_WR;
      op_legal     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      chk_valid_q  <= 1'b0;
      draw_valid_q <= 1'b0;
      chk_data_q   <= '0;
      draw_data_q  <= '0;
    end else begin
      chk_valid_q  <= 1'b0;
      draw_valid_q <= 1'b0;
      if (arb_en) begin
        owner    <= sel_owner;
        op_legal <= sel_legal;
        addr_q   <= pack_addr(sel_y, sel_x);
        if (grant[0]) wdata_q <= bus.wr_data;
      end
      if (state == ST_WAIT) begin
        if (owner == OWN_CHK) begin
          chk_valid_q <= 1'b1;
          chk_data_q  <= rd_cell;
        end else begin
          draw_valid_q <= 1'b1;
          draw_data_q  <= rd_cell;
        end
      end
    end
  end

  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.chk_valid  = chk_valid_q;
  assign bus.chk_data   = chk_data_q;
  assign bus.draw_valid = draw_valid_q;
  assign bus.draw_data  = draw_data_q;

endmodule
